muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Execute-stage responder for the multiply/divide requests raised by instruction decode: `mult`, `multu`, `div`, `divu`, `mul`, `mthi`, `mtlo`.
- Owns the architectural HI/LO registers.
- Multiplies in a fixed 2 cycles; divides iteratively, one quotient bit per cycle.
- Drives `busy` so the pipeline holds a new request, or an `mfhi`/`mflo` read, until results are final.

## Interface
Parameters:
- `DIV_ITERS`, 32: quotient bits produced, one per cycle.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  reset; one clock, asynchronous, active-low.
- `req_valid`  in  1  request present this cycle.
- `is_mult`  in  1  signed multiply; also set for `mul`.
- `is_multu`  in  1  unsigned multiply.
- `is_div`  in  1  signed divide.
- `is_divu`  in  1  unsigned divide.
- `is_mul_gpr`  in  1  `mul`: product goes to `product` only; HI/LO are not written.
- `hi_wen`  in  1  `mthi`: HI <= `src_a`.
- `lo_wen`  in  1  `mtlo`: LO <= `src_a`.
- `src_a`  in  32  rs data; dividend or multiplicand.
- `src_b`  in  32  rt data; divisor or multiplier.
- `cancel`  in  1  exception flush; abandons the in-flight operation.
- `busy`  out  1  registered; high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after a mult or div completes.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `product`  out  32  low word of the last completed multiply.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: state IDLE; `busy`, `done`, `hi`, `lo`, `product` all 0; iteration counter 0.
- Request acceptance:
  - A request is accepted only when `req_valid & ~busy & ~cancel`. Otherwise it is ignored.
  - The issuer must hold the request until `busy` is low.
- At most one op flag is set per request. If more are set, priority is div > divu > mult > multu > hi_wen/lo_wen. `hi_wen` and `lo_wen` together write both.
- `mthi`/`mtlo`: register written at the accepting edge; state stays IDLE; no `done` pulse.
- Multiply:
  - Accept: capture operands and signedness; go to MUL.
  - MUL cycle: form a 33×33 signed product of the operands sign-extended (`mult`) or zero-extended (`multu`). Keep bits [63:0].
  - MUL exit edge: `product` <= [31:0]. If `is_mul_gpr` was 0, also {HI,LO} <= [63:0]. Go to IDLE.
- Divide:
  - Accept: capture |a| and |b| (signed ops only; unsigned ops take operands as-is), sign of a, sign of a XOR sign of b, and a zero-divisor flag. Clear the counter. Go to DIV, or straight to FIX if the divisor is 0.
  - DIV: restoring radix-2 step. Shift the {rem, quot} 64-bit register left by 1. Trial-subtract the divisor from rem[32:0]. If non-negative, keep the difference and set quot[0].
  - Counter increments each DIV cycle. Go to FIX when the counter reaches `DIV_ITERS-1`.
  - FIX: LO <= quotient, negated if signs differed. HI <= remainder, negated if the dividend was negative. Go to IDLE.
  - Divisor 0: LO <= 0xFFFF_FFFF, HI <= `src_a` as captured. No exception is raised.
  - 0x8000_0000 / −1 (signed): LO = 0x8000_0000, HI = 0. This falls out of the magnitude path; no special case.
- `done` is high in the cycle after the MUL or FIX exit edge, i.e. the first IDLE cycle.
- Cancel:
  - `cancel` in any non-IDLE state: next state IDLE. HI, LO and `product` are left unchanged. No `done` pulse. Counter cleared.
  - `cancel` in the same cycle as a request drops that request.
- A request presented in the `done` cycle is accepted; back-to-back operations are legal.

## Timing
- Cycle 0 = request-accepting cycle.
- mult/multu/mul: `busy` high in cycle 1. Results visible and `done` high in cycle 2. New request accepted in cycle 2.
- div/divu: `busy` high in cycles 1..33 (32 DIV cycles, then FIX). Results and `done` in cycle 34.
- Divide by zero: `busy` high in cycle 1 (FIX only). Results in cycle 2.
- mthi/mtlo: value visible in cycle 1. `busy` stays low.
- `resetn` low mid-operation: all outputs return to their reset values immediately (asynchronous); the operation is lost.

## Structure
- Package `muldiv_pkg` holds:
  - State encoding.
  - `DIV_ITERS` default.
  - Divide-by-zero constants for LO and HI source.
- One sub-module, `div_core`:
  - Contains the 64-bit {rem, quot} shift register, the 33-bit trial subtractor and the 5-bit counter.
  - `start` / `done` handshake.
  - Sign handling and HI/LO writes stay in the top.

## Test plan
- `mult` 0xFFFF_FFFF × 0x0000_0002 -> `busy` high in cycle 1; cycle 2: HI=0xFFFF_FFFF, LO=0xFFFF_FFFE, `done`=1. `multu` same operands -> HI=0x0000_0001, LO=0xFFFF_FFFE.
- `div` −7 / 2 -> `busy` high for 33 cycles; cycle 34: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. `divu` 100 / 7 -> LO=14, HI=2.
- `div` 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0. `divu` 5 / 0 -> cycle 2: LO=0xFFFF_FFFF, HI=5.
- `mul` 3 × −4 with HI=0x11, LO=0x22 preset via mthi/mtlo -> `product`=0xFFFF_FFF4; HI/LO unchanged.
- `cancel` asserted in DIV cycle 10 -> IDLE next cycle, no `done`, HI/LO keep prior values. A request held during `busy` is accepted in the `done` cycle.
- `resetn` pulsed low during DIV -> `busy`=0, HI=LO=`product`=0 immediately. The next `divu` completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    typedef enum logic {
        HI_FROM_REM,
        HI_FROM_DIVIDEND
    } hi_src_e;

    localparam int unsigned DIV_ITERS_DEFAULT = 32;

    // Divide by zero: LO saturates, HI returns the dividend unchanged.
    localparam logic [31:0] DZ_LO     = 32'hFFFF_FFFF;
    localparam hi_src_e     DZ_HI_SRC = HI_FROM_DIVIDEND;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between instruction decode/issue and the multiply/divide unit.
interface muldiv_if;

    logic        req_valid;
    logic        is_mult;
    logic        is_multu;
    logic        is_div;
    logic        is_divu;
    logic        is_mul_gpr;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] product;

    modport master (
        output req_valid, is_mult, is_multu, is_div, is_divu, is_mul_gpr,
               hi_wen, lo_wen, src_a, src_b, cancel,
        input  busy, done, hi, lo, product
    );

    modport slave (
        input  req_valid, is_mult, is_multu, is_div, is_divu, is_mul_gpr,
               hi_wen, lo_wen, src_a, src_b, cancel,
        output busy, done, hi, lo, product
    );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle on magnitudes.
module div_core
    import muldiv_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam int unsigned      CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_ITERS - 1);

    logic [63:0]      rq;
    logic [63:0]      rq_next;
    logic [31:0]      dvsr;
    logic [33:0]      diff;
    logic [CNT_W-1:0] count;
    logic             running;

    // Shifted remainder is 33 bits wide; a non-negative difference always fits in 32.
    always_comb begin
        diff = {1'b0, rq[63:31]} - {2'b00, dvsr};
        if (diff[33:32] == 2'b00) begin
            rq_next = {diff[31:0], rq[30:0], 1'b1};
        end else begin
            rq_next = {rq[62:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq      <= '0;
            dvsr    <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            rq      <= {32'd0, dividend};
            dvsr    <= divisor;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            rq <= rq_next;
            if (count == LAST) begin
                count   <= '0;
                running <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // High during the final step, so the caller can leave DIV on the same edge.
    assign done = running && (count == LAST);
    assign quot = rq[31:0];
    assign rem  = rq[63:32];

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; 2-cycle multiply, iterative divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    state_e      state;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] prod_q;

    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic        mul_gpr;
    logic [63:0] mul_full;

    logic        a_neg;
    logic        q_neg;
    logic        dz;
    logic [31:0] dz_dividend;

    logic        accept;
    logic        is_div_op;
    logic        div_signed;
    logic        start_div;
    logic        core_done;
    logic [31:0] core_quot;
    logic [31:0] core_rem;

    hi_src_e     hi_src;
    logic [31:0] fix_lo;
    logic [31:0] fix_hi;

    assign accept     = bus.req_valid & ~busy_q & ~bus.cancel;
    assign is_div_op  = bus.is_div | bus.is_divu;
    assign div_signed = bus.is_div;
    assign start_div  = accept & is_div_op & (bus.src_b != '0);

    // 33x33 signed product, taken modulo 2^64 on sign-extended operands.
    assign mul_full = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

    always_comb begin
        hi_src = dz ? DZ_HI_SRC : HI_FROM_REM;
        fix_lo = dz ? DZ_LO : (q_neg ? -core_quot : core_quot);
        if (hi_src == HI_FROM_DIVIDEND) begin
            fix_hi = dz_dividend;
        end else begin
            fix_hi = a_neg ? -core_rem : core_rem;
        end
    end

    div_core #(
        .DIV_ITERS(DIV_ITERS)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start_div),
        .clear    (bus.cancel & (state != S_IDLE)),
        .dividend (mag32(bus.src_a, div_signed)),
        .divisor  (mag32(bus.src_b, div_signed)),
        .done     (core_done),
        .quot     (core_quot),
        .rem      (core_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            prod_q      <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_gpr     <= 1'b0;
            a_neg       <= 1'b0;
            q_neg       <= 1'b0;
            dz          <= 1'b0;
            dz_dividend <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_div_op) begin
                            a_neg       <= div_signed & bus.src_a[31];
                            q_neg       <= div_signed & (bus.src_a[31] ^ bus.src_b[31]);
                            dz          <= (bus.src_b == '0);
                            dz_dividend <= bus.src_a;
                            busy_q      <= 1'b1;
                            state       <= (bus.src_b == '0) ? S_FIX : S_DIV;
                        end else if (bus.is_mult | bus.is_multu) begin
                            mul_a   <= {bus.is_mult & bus.src_a[31], bus.src_a};
                            mul_b   <= {bus.is_mult & bus.src_b[31], bus.src_b};
                            mul_gpr <= bus.is_mul_gpr;
                            busy_q  <= 1'b1;
                            state   <= S_MUL;
                        end else begin
                            if (bus.hi_wen) hi_q <= bus.src_a;
                            if (bus.lo_wen) lo_q <= bus.src_a;
                        end
                    end
                end
                S_MUL: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                    if (!bus.cancel) begin
                        prod_q <= mul_full[31:0];
                        if (!mul_gpr) begin
                            hi_q <= mul_full[63:32];
                            lo_q <= mul_full[31:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (core_done) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                    if (!bus.cancel) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.product = prod_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply, divide, mthi/mtlo, cancel and async reset.
module tb_muldiv_unit;

    localparam logic [6:0] OP_DIV   = 7'b1000000;
    localparam logic [6:0] OP_DIVU  = 7'b0100000;
    localparam logic [6:0] OP_MULT  = 7'b0010000;
    localparam logic [6:0] OP_MULTU = 7'b0001000;
    localparam logic [6:0] OP_GPR   = 7'b0000100;
    localparam logic [6:0] OP_MTHI  = 7'b0000010;
    localparam logic [6:0] OP_MTLO  = 7'b0000001;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n;

    muldiv_if bus();

    muldiv_unit #(
        .DIV_ITERS(32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [6:0] ops,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = v;
        {bus.is_div, bus.is_divu, bus.is_mult, bus.is_multu,
         bus.is_mul_gpr, bus.hi_wen, bus.lo_wen} = ops;
        bus.src_a = a;
        bus.src_b = b;
    endtask

    // Present a request in the current (idle) cycle; returns in cycle 1.
    task automatic issue(input logic [6:0] ops, input logic [31:0] a, input logic [31:0] b);
        set_req(1'b1, ops, a, b);
        tick();
        set_req(1'b0, 7'd0, 32'd0, 32'd0);
    endtask

    task automatic run_until_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        set_req(1'b0, 7'd0, 32'd0, 32'd0);
        bus.cancel = 1'b0;
        #12;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_hi", bus.hi, 32'd0);
        check_eq("rst_lo", bus.lo, 32'd0);
        check_eq("rst_product", bus.product, 32'd0);
        #10 resetn = 1'b1;
        tick();

        // mult -1 x 2, then multu presented in the done cycle
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check_eq("mult_busy_c1", 32'(bus.busy), 32'd1);
        check_eq("mult_done_c1", 32'(bus.done), 32'd0);
        tick();
        check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", bus.lo, 32'hFFFF_FFFE);
        check_eq("mult_done_c2", 32'(bus.done), 32'd1);
        check_eq("mult_busy_c2", 32'(bus.busy), 32'd0);
        check_eq("mult_product", bus.product, 32'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        check_eq("multu_busy_c1", 32'(bus.busy), 32'd1);
        tick();
        check_eq("multu_hi", bus.hi, 32'h0000_0001);
        check_eq("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // divu by zero
        issue(OP_DIVU, 32'd5, 32'd0);
        run_until_idle(n);
        check_eq("dz_busy_cycles", n, 32'd1);
        check_eq("dz_done", 32'(bus.done), 32'd1);
        check_eq("dz_lo", bus.lo, 32'hFFFF_FFFF);
        check_eq("dz_hi", bus.hi, 32'd5);

        // div -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_until_idle(n);
        check_eq("div_busy_cycles", n, 32'd33);
        check_eq("div_done", 32'(bus.done), 32'd1);
        check_eq("div_lo", bus.lo, 32'hFFFF_FFFD);
        check_eq("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd100, 32'd7);
        run_until_idle(n);
        check_eq("divu_busy_cycles", n, 32'd33);
        check_eq("divu_lo", bus.lo, 32'd14);
        check_eq("divu_hi", bus.hi, 32'd2);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_until_idle(n);
        check_eq("divmin_lo", bus.lo, 32'h8000_0000);
        check_eq("divmin_hi", bus.hi, 32'd0);

        // mthi+mtlo together, then separate presets
        issue(OP_MTHI | OP_MTLO, 32'h55, 32'd0);
        check_eq("mthilo_busy", 32'(bus.busy), 32'd0);
        check_eq("mthilo_hi", bus.hi, 32'h55);
        check_eq("mthilo_lo", bus.lo, 32'h55);
        issue(OP_MTHI, 32'h11, 32'd0);
        check_eq("mthi_hi", bus.hi, 32'h11);
        check_eq("mthi_lo_kept", bus.lo, 32'h55);
        issue(OP_MTLO, 32'h22, 32'd0);
        check_eq("mtlo_lo", bus.lo, 32'h22);
        check_eq("mtlo_done", 32'(bus.done), 32'd0);

        // mul 3 x -4 leaves HI/LO alone
        issue(OP_MULT | OP_GPR, 32'd3, 32'hFFFF_FFFC);
        tick();
        check_eq("mul_product", bus.product, 32'hFFFF_FFF4);
        check_eq("mul_done", 32'(bus.done), 32'd1);
        check_eq("mul_hi", bus.hi, 32'h11);
        check_eq("mul_lo", bus.lo, 32'h22);

        // cancel in DIV cycle 10
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c < 10; c++) tick();
        check_eq("cancel_busy_c10", 32'(bus.busy), 32'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check_eq("cancel_busy", 32'(bus.busy), 32'd0);
        check_eq("cancel_done", 32'(bus.done), 32'd0);
        check_eq("cancel_hi", bus.hi, 32'h11);
        check_eq("cancel_lo", bus.lo, 32'h22);
        tick();
        check_eq("cancel_done_late", 32'(bus.done), 32'd0);
        check_eq("cancel_busy_late", 32'(bus.busy), 32'd0);

        // request held during busy is taken in the done cycle
        issue(OP_DIVU, 32'd100, 32'd7);
        set_req(1'b1, OP_MULTU, 32'd3, 32'd5);
        run_until_idle(n);
        check_eq("held_div_cycles", n, 32'd33);
        check_eq("held_div_done", 32'(bus.done), 32'd1);
        check_eq("held_div_lo", bus.lo, 32'd14);
        tick();
        set_req(1'b0, 7'd0, 32'd0, 32'd0);
        check_eq("held_accept_busy", 32'(bus.busy), 32'd1);
        tick();
        check_eq("held_mul_lo", bus.lo, 32'd15);
        check_eq("held_mul_hi", bus.hi, 32'd0);
        check_eq("held_mul_done", 32'(bus.done), 32'd1);

        // async reset mid-divide
        issue(OP_DIVU, 32'd1000, 32'd3);
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_hi", bus.hi, 32'd0);
        check_eq("arst_lo", bus.lo, 32'd0);
        check_eq("arst_product", bus.product, 32'd0);
        #3 resetn = 1'b1;
        tick();
        issue(OP_DIVU, 32'd100, 32'd7);
        run_until_idle(n);
        check_eq("post_rst_cycles", n, 32'd33);
        check_eq("post_rst_lo", bus.lo, 32'd14);
        check_eq("post_rst_hi", bus.hi, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
